// File: rtl/gcd_fpga_pkg.sv
// Shared types and defaults for the GCD board front-end (operand feeder and friends).
package gcd_fpga_pkg;

    localparam int GCD_DW = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        BUSY = 2'd2
    } feeder_state_t;

    // Counter width able to hold 0 .. n-1, never narrower than one bit.
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// Push-button conditioner: synchroniser, stability counter, debounced level and
// a single-cycle pulse on each debounced rising edge.
module btn_debounce
    import gcd_fpga_pkg::*;
#(
    parameter int          SYNC_STAGES     = 2,
    parameter logic [19:0] DEBOUNCE_CYCLES = 20'd1_000_000
) (
    input  logic clk,
    input  logic reset,
    input  logic btn_raw,
    output logic stable,
    output logic press
);

    localparam int unsigned    CW       = cnt_width(int'(DEBOUNCE_CYCLES));
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 20'd1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   btn_sync;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic                   level_q, level_d;
    logic                   level_dly_q;

    assign btn_sync = sync_q[SYNC_STAGES-1];

    // NOTE: every variable gets a default before any branch so no latch is inferred.
    always_comb begin
        cnt_d   = '0;
        level_d = level_q;
        if (btn_sync != level_q) begin
            if (cnt_q == CNT_LAST) begin
                level_d = btn_sync;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    // NOTE: state registers use non-blocking assignments so all flops update together.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_q      <= '0;
            cnt_q       <= '0;
            level_q     <= 1'b0;
            level_dly_q <= 1'b0;
        end else begin
            sync_q      <= {sync_q[SYNC_STAGES-2:0], btn_raw};
            cnt_q       <= cnt_d;
            level_q     <= level_d;
            level_dly_q <= level_q;
        end
    end

    assign stable = level_q;
    assign press  = level_q & ~level_dly_q;

endmodule

// File: rtl/gcd_operand_feeder.sv
// Switch/button front-end driving the GCD input handshake: synchronises operands,
// captures them on a debounced press, holds the request until the result returns.
// Optional ZERO_GUARD_EN rejects presses with a zero operand and raises zero_err.
module gcd_operand_feeder
    import gcd_fpga_pkg::*;
#(
    parameter int          DW              = GCD_DW,
    parameter int          SYNC_STAGES     = 2,
    parameter logic [19:0] DEBOUNCE_CYCLES = 20'd1_000_000
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [DW-1:0] sw_x,
    input  logic [DW-1:0] sw_y,
    input  logic          btn_start,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] out_bits_x,
    output logic [DW-1:0] out_bits_y,
    input  logic          result_valid,
    output logic          busy,
    output logic          overrun,
    output logic          zero_err
);

    feeder_state_t state_q, state_d;

    logic [DW-1:0] x_sync_q [SYNC_STAGES];
    logic [DW-1:0] y_sync_q [SYNC_STAGES];
    logic [DW-1:0] x_synced, y_synced;
    logic [DW-1:0] bits_x_q, bits_y_q;
    logic          overrun_q, overrun_d;
    logic          capture;
    logic          press;
    logic          btn_stable;
    logic          unused_stable;

    btn_debounce #(
        .SYNC_STAGES     (SYNC_STAGES),
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_btn (
        .clk     (clk),
        .reset   (reset),
        .btn_raw (btn_start),
        .stable  (btn_stable),
        .press   (press)
    );

    // The debounced level is not needed here; only its rising-edge pulse is.
    assign unused_stable = btn_stable;

    // Switches are static between presses, so plain synchronisers suffice.
    // NOTE: the synchroniser arrays are reset explicitly; they are flops, not RAM.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                x_sync_q[i] <= '0;
                y_sync_q[i] <= '0;
            end
        end else begin
            x_sync_q[0] <= sw_x;
            y_sync_q[0] <= sw_y;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                x_sync_q[i] <= x_sync_q[i-1];
                y_sync_q[i] <= y_sync_q[i-1];
            end
        end
    end

    assign x_synced = x_sync_q[SYNC_STAGES-1];
    assign y_synced = y_sync_q[SYNC_STAGES-1];

`ifdef ZERO_GUARD_EN
    logic zero_err_q, zero_err_d;
    logic operands_ok;

    assign operands_ok = (|x_synced) && (|y_synced);
`endif

    always_comb begin
        state_d   = state_q;
        overrun_d = overrun_q;
        capture   = 1'b0;
`ifdef ZERO_GUARD_EN
        zero_err_d = zero_err_q;
`endif
        case (state_q)
            IDLE: begin
                if (press) begin
`ifdef ZERO_GUARD_EN
                    if (operands_ok) begin
                        capture    = 1'b1;
                        state_d    = REQ;
                        zero_err_d = 1'b0;
                    end else begin
                        zero_err_d = 1'b1;
                    end
`else
                    capture = 1'b1;
                    state_d = REQ;
`endif
                end
            end
            REQ: begin
                if (press) overrun_d = 1'b1;
                if (out_ready) state_d = BUSY;
            end
            BUSY: begin
                // A press coinciding with the result is dropped, not queued.
                if (press) overrun_d = 1'b1;
                if (result_valid) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            overrun_q <= 1'b0;
            bits_x_q  <= '0;
            bits_y_q  <= '0;
        end else begin
            state_q   <= state_d;
            overrun_q <= overrun_d;
            if (capture) begin
                bits_x_q <= x_synced;
                bits_y_q <= y_synced;
            end
        end
    end

`ifdef ZERO_GUARD_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) zero_err_q <= 1'b0;
        else       zero_err_q <= zero_err_d;
    end

    assign zero_err = zero_err_q;
`else
    assign zero_err = 1'b0;
`endif

    // Decoded straight from the state flops so reset drops them without a clock.
    assign out_valid  = (state_q == REQ);
    assign busy       = (state_q != IDLE);
    assign overrun    = overrun_q;
    assign out_bits_x = bits_x_q;
    assign out_bits_y = bits_y_q;

endmodule
